axi3_ram_slave: RTL and testbench

//  AXI3 responder (slave end) backed by an internal word-addressed RAM; pairs with the master modport of the AXI3 interface.

---
 rtl/axi3_ram_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi3_ram_slave.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_ram_slave.sv
// AXI3 slave backed by a word-addressed RAM. One burst in flight at a time,
// FIXED and INCR bursts only; WRAP/reserved bursts and oversize beats answer SLVERR.
module axi3_ram_slave #(
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned ADDR_BYTES    = 4,
  parameter int unsigned NUM_ID_BITS_P = 4,
  parameter int unsigned DEPTH         = 1024
) (
  input  logic                       aclk,
  input  logic                       areset,
  // write address
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ADDR_BYTES*8-1:0]    awaddr,
  input  logic [NUM_ID_BITS_P-1:0]   awid,
  input  logic [3:0]                 awlen,
  input  logic [2:0]                 awsize,
  input  logic [1:0]                 awburst,
  input  logic [3:0]                 awcache,
  input  logic [2:0]                 awprot,
  input  logic [1:0]                 awlock,
  // write data
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [DATA_BYTES*8-1:0]    wdata,
  input  logic [DATA_BYTES-1:0]      wstrb,
  input  logic                       wlast,
  input  logic [NUM_ID_BITS_P-1:0]   wid,
  // write response
  output logic                       bwvalid,
  input  logic                       bwready,
  output logic [1:0]                 bresp,
  output logic [NUM_ID_BITS_P-1:0]   bid,
  // read address
  input  logic                       arvalid,
  output logic                       aready,
  input  logic [ADDR_BYTES*8-1:0]    araddr,
  input  logic [NUM_ID_BITS_P-1:0]   arid,
  input  logic [3:0]                 arlen,
  input  logic [2:0]                 arsize,
  input  logic [1:0]                 arburst,
  input  logic [3:0]                 arcache,
  input  logic [2:0]                 arprot,
  input  logic [1:0]                 arlock,
  // read data
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_BYTES*8-1:0]    rdata,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic [NUM_ID_BITS_P-1:0]   rid
);

  localparam int unsigned DW       = DATA_BYTES * 8;
  localparam int unsigned AW       = ADDR_BYTES * 8;
  localparam int unsigned ADDR_LSB = $clog2(DATA_BYTES);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [2:0]  MAX_SIZE = 3'(ADDR_LSB);

  typedef enum logic [1:0] {StIdle, StWdata, StWresp, StRdata} state_e;

  state_e                   state_q;
  logic                     prio_q;   // 0: write wins a tie, 1: read wins
  logic [NUM_ID_BITS_P-1:0] id_q;
  logic [AW-1:0]            addr_q;
  logic [3:0]               len_q;
  logic [3:0]               beat_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic                     err_q;

  logic [DW-1:0] mem [DEPTH];

  logic          idle;
  logic          aw_hs, ar_hs, w_hs;
  logic          last_beat;
  logic          w_err;
  logic          mem_we;
  logic [AW-1:0] size_bytes;
  logic [AW-1:0] next_addr;
  logic          unused_sideband;

  function automatic logic ax_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] | (size > MAX_SIZE);
  endfunction

  assign unused_sideband = ^{awcache, awprot, awlock, arcache, arprot, arlock};

  assign idle    = (state_q == StIdle);
  assign awready = idle & awvalid & (~arvalid | ~prio_q);
  assign aready  = idle & arvalid & (~awvalid | prio_q);
  assign aw_hs   = awvalid & awready;
  assign ar_hs   = arvalid & aready;
  assign w_hs    = wvalid & wready;

  assign last_beat = (beat_q == len_q);
  // A bad beat poisons itself and everything after it in the burst.
  assign w_err  = err_q | (wid != id_q) | (wlast != last_beat);
  assign mem_we = (state_q == StWdata) & w_hs & ~w_err & ~areset;

  // Address of the following beat: FIXED holds, INCR aligns to size then steps.
  always_comb begin
    size_bytes = AW'(1) << size_q;
    next_addr  = addr_q;
    if (burst_q == 2'b01) begin
      next_addr = (addr_q & ~(size_bytes - AW'(1))) + size_bytes;
    end
  end

  // Byte-lane RAM write; contents are deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        if (wstrb[i]) begin
          mem[addr_q[ADDR_LSB +: IDX_W]][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered channel outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      wready  <= 1'b0;
      bwvalid <= 1'b0;
      bresp   <= 2'b00;
      bid     <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= '0;
      rid     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aw_hs) begin
            prio_q  <= 1'b1;
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            beat_q  <= '0;
            err_q   <= ax_err(awburst, awsize);
            wready  <= 1'b1;
            state_q <= StWdata;
          end else if (ar_hs) begin
            prio_q  <= 1'b0;
            id_q    <= arid;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            beat_q  <= '0;
            err_q   <= ax_err(arburst, arsize);
            rvalid  <= 1'b1;
            rid     <= arid;
            rlast   <= (arlen == 4'd0);
            rresp   <= ax_err(arburst, arsize) ? 2'b10 : 2'b00;
            rdata   <= ax_err(arburst, arsize) ? '0 : mem[araddr[ADDR_LSB +: IDX_W]];
            state_q <= StRdata;
          end
        end
        StWdata: begin
          if (w_hs) begin
            err_q  <= w_err;
            addr_q <= next_addr;
            beat_q <= beat_q + 4'd1;
            if (last_beat) begin
              wready  <= 1'b0;
              bwvalid <= 1'b1;
              bid     <= id_q;
              bresp   <= w_err ? 2'b10 : 2'b00;
              state_q <= StWresp;
            end
          end
        end
        StWresp: begin
          if (bwready) begin
            bwvalid <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRdata: begin
          if (rready) begin
            if (last_beat) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              state_q <= StIdle;
            end else begin
              // Load the next beat on the accepting edge to keep full rate.
              addr_q <= next_addr;
              beat_q <= beat_q + 4'd1;
              rlast  <= ((beat_q + 4'd1) == len_q);
              rdata  <= err_q ? '0 : mem[next_addr[ADDR_LSB +: IDX_W]];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_ram_slave.sv
// Randomized bench for axi3_ram_slave against a transaction-level memory model.
module tb_axi3_ram_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid, awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [1:0]  awlock;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [3:0]  wid;
  logic        bwvalid, bwready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, aready;
  logic [31:0] araddr;
  logic [3:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [1:0]  arlock;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  axi3_ram_slave dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awcache(awcache), .awprot(awprot), .awlock(awlock),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
    .bwvalid(bwvalid), .bwready(bwready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .aready(aready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache), .arprot(arprot), .arlock(arlock),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 aclk = ~aclk;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [1024];
  int          model_prio;   // 0: write wins a tie
  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];
  logic [31:0] rcap [16];
  logic [1:0]  exp_bresp, last_bresp;
  logic [3:0]  wr_id, wr_len, rd_id, rd_len;
  logic [31:0] wr_addr, rd_addr;
  logic [2:0]  wr_size, rd_size;
  logic [1:0]  wr_burst, rd_burst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] s,
                                      input logic [1:0] b);
    logic [31:0] n;
    n = 32'd1 << s;
    if (b == 2'd0) return a;
    return (a / n) * n + n;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic bit bad_ax(input logic [1:0] b, input logic [2:0] s);
    return (b >= 2'd2) || (s > 3'd2);
  endfunction

  task automatic aw_set(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    wr_id = id; wr_addr = a; wr_len = len; wr_size = size; wr_burst = burst;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst;
    awcache = 4'($urandom); awprot = 3'($urandom); awlock = 2'($urandom);
    awvalid = 1'b1;
  endtask

  task automatic aw_wait();
    int n = 0;
    bit hs;
    while (1) begin
      #1 hs = awready;
      @(negedge aclk);
      if (hs) break;
      if (++n > 200) begin check("aw_timeout", 0, 1); break; end
    end
    awvalid = 1'b0;
    model_prio = 1;
  endtask

  task automatic ar_set(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    rd_id = id; rd_addr = a; rd_len = len; rd_size = size; rd_burst = burst;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst;
    arcache = 4'($urandom); arprot = 3'($urandom); arlock = 2'($urandom);
    arvalid = 1'b1;
  endtask

  task automatic ar_wait();
    int n = 0;
    bit hs;
    while (1) begin
      #1 hs = aready;
      @(negedge aclk);
      if (hs) break;
      if (++n > 200) begin check("ar_timeout", 0, 1); break; end
    end
    arvalid = 1'b0;
    model_prio = 0;
  endtask

  // Drives the data beats and applies the burst to the reference memory.
  task automatic w_phase(input int wid_bad, input int wlast_bad);
    int n;
    bit hs;
    bit err;
    logic [31:0] a;
    for (int b = 0; b <= int'(wr_len); b++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
      wvalid = 1'b1;
      wdata  = wbuf_data[b];
      wstrb  = wbuf_strb[b];
      wid    = (b == wid_bad) ? ~wr_id : wr_id;
      wlast  = (b == int'(wr_len)) ^ (b == wlast_bad);
      n = 0;
      while (1) begin
        #1 hs = wready;
        @(negedge aclk);
        if (hs) break;
        if (++n > 200) begin check("w_timeout", 0, 1); break; end
      end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    #1 check("wready_after_last", wready, 0);
    err = bad_ax(wr_burst, wr_size);
    a = wr_addr;
    for (int b = 0; b <= int'(wr_len); b++) begin
      if (b == wid_bad || b == wlast_bad) err = 1'b1;
      if (!err) begin
        for (int i = 0; i < 4; i++) begin
          if (wbuf_strb[b][i]) ref_mem[widx(a)][i*8 +: 8] = wbuf_data[b][i*8 +: 8];
        end
      end
      a = nxt(a, wr_size, wr_burst);
    end
    exp_bresp = err ? 2'b10 : 2'b00;
  endtask

  task automatic b_phase();
    int n = 0;
    bit v, r, seen;
    seen = 1'b0;
    while (1) begin
      bwready = ($urandom_range(0, 2) != 0);
      #1 v = bwvalid;
      r = bwready;
      if (v && !seen) begin
        check("bresp", bresp, exp_bresp);
        check("bid", bid, wr_id);
        last_bresp = bresp;
        seen = 1'b1;
      end
      @(negedge aclk);
      if (v && r) break;
      if (++n > 200) begin check("b_timeout", 0, 1); break; end
    end
    bwready = 1'b0;
  endtask

  task automatic r_phase();
    logic [31:0] want [16];
    logic [31:0] a;
    bit err;
    int beat, n;
    err = bad_ax(rd_burst, rd_size);
    a = rd_addr;
    for (int b = 0; b <= int'(rd_len); b++) begin
      want[b] = err ? 32'd0 : ref_mem[widx(a)];
      a = nxt(a, rd_size, rd_burst);
    end
    beat = 0;
    n = 0;
    while (beat <= int'(rd_len)) begin
      rready = ($urandom_range(0, 9) < 6);
      #1 check("rvalid_in_burst", rvalid, 1);
      if (!rvalid) break;
      check("rdata", rdata, want[beat]);
      if (rready) begin
        check("rlast", rlast, beat == int'(rd_len));
        check("rresp", rresp, err ? 2'b10 : 2'b00);
        check("rid", rid, rd_id);
        rcap[beat] = rdata;
        beat++;
      end
      @(negedge aclk);
      if (++n > 400) begin check("r_timeout", 0, 1); break; end
    end
    rready = 1'b0;
    #1 check("rvalid_after_last", rvalid, 0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wid_bad, input int wlast_bad);
    aw_set(id, a, len, size, burst);
    aw_wait();
    w_phase(wid_bad, wlast_bad);
    b_phase();
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_set(id, a, len, size, burst);
    ar_wait();
    r_phase();
  endtask

  task automatic fill_wbuf(input bit rand_strb);
    for (int b = 0; b < 16; b++) begin
      wbuf_data[b] = $urandom;
      wbuf_strb[b] = rand_strb ? 4'($urandom) : 4'hF;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  tid, tlen;
    logic [31:0] taddr;
    logic [2:0]  tsize;
    logic [1:0]  tburst;
    int          wb, lb;

    areset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    awcache = 0; awprot = 0; awlock = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wid = 0; bwready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    arcache = 0; arprot = 0; arlock = 0; rready = 0;
    model_prio = 0;
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bwvalid", bwvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp_bid", {bresp, bid}, 0);
    check("rst_rresp_rid", {rresp, rid}, 0);
    check("rst_rdata", rdata, 0);
    areset = 1'b0;

    // Give the whole RAM defined contents.
    for (int k = 0; k < 64; k++) begin
      fill_wbuf(1'b0);
      do_write(4'($urandom), 32'(k * 64), 4'd15, 3'd2, 2'd1, -1, -1);
    end

    // INCR write/read round trip
    for (int b = 0; b < 4; b++) begin wbuf_data[b] = 32'hA0 + 32'(b); wbuf_strb[b] = 4'hF; end
    do_write(4'h3, 32'h10, 4'd3, 3'd2, 2'd1, -1, -1);
    check("t1_bresp", last_bresp, 2'b00);
    do_read(4'h5, 32'h10, 4'd3, 3'd2, 2'd1);
    for (int b = 0; b < 4; b++) check("t1_readback", rcap[b], 32'hA0 + 32'(b));

    // Strobed merge
    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    do_write(4'h1, 32'h20, 4'd0, 3'd2, 2'd1, -1, -1);
    wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'b0101;
    do_write(4'h1, 32'h20, 4'd0, 3'd2, 2'd1, -1, -1);
    do_read(4'h1, 32'h20, 4'd0, 3'd2, 2'd1);
    check("t2_merge", rcap[0], 32'hDE22BE44);

    // FIXED burst lands every beat on one word; WRAP/reserved/oversize are rejected
    for (int b = 0; b < 3; b++) begin wbuf_data[b] = 32'(b + 1); wbuf_strb[b] = 4'hF; end
    do_write(4'h2, 32'h30, 4'd2, 3'd2, 2'd0, -1, -1);
    do_read(4'h2, 32'h30, 4'd0, 3'd2, 2'd1);
    check("t3_fixed", rcap[0], 32'd3);
    fill_wbuf(1'b0);
    do_write(4'h4, 32'h40, 4'd3, 3'd2, 2'd2, -1, -1);
    check("t3_wrap_resp", last_bresp, 2'b10);
    do_write(4'h4, 32'h40, 4'd3, 3'd2, 2'd3, -1, -1);
    check("t3_rsvd_resp", last_bresp, 2'b10);
    do_write(4'h4, 32'h40, 4'd3, 3'd3, 2'd1, -1, -1);
    check("t3_size_resp", last_bresp, 2'b10);
    do_read(4'h6, 32'h40, 4'd3, 3'd2, 2'd1);
    do_read(4'h6, 32'h40, 4'd3, 3'd2, 2'd2);

    // Simultaneous requests alternate priority
    fill_wbuf(1'b0);
    aw_set(4'h1, 32'h200, 4'd1, 3'd2, 2'd1);
    ar_set(4'h2, 32'h10, 4'd3, 3'd2, 2'd1);
    #1 check("t4_aw_first", awready, model_prio == 0);
    check("t4_ar_waits", aready, model_prio == 1);
    aw_wait();
    w_phase(-1, -1);
    b_phase();
    fill_wbuf(1'b0);
    aw_set(4'h3, 32'h204, 4'd0, 3'd2, 2'd1);
    #1 check("t4_ar_first", aready, model_prio == 1);
    check("t4_aw_waits", awready, model_prio == 0);
    ar_wait();
    r_phase();
    aw_wait();
    w_phase(-1, -1);
    b_phase();

    // Long read under random backpressure
    do_read(4'h7, 32'h100, 4'd7, 3'd2, 2'd1);

    // Early wlast and bad wid poison the rest of the burst
    fill_wbuf(1'b0);
    do_write(4'h8, 32'h80, 4'd3, 3'd2, 2'd1, -1, 1);
    check("t6_wlast_resp", last_bresp, 2'b10);
    do_read(4'h8, 32'h80, 4'd3, 3'd2, 2'd1);
    fill_wbuf(1'b0);
    do_write(4'h9, 32'h90, 4'd3, 3'd2, 2'd1, 2, -1);
    check("t6_wid_resp", last_bresp, 2'b10);
    do_read(4'h9, 32'h90, 4'd3, 3'd2, 2'd1);

    // Reset in the middle of a read burst
    ar_set(4'hA, 32'h100, 4'd7, 3'd2, 2'd1);
    ar_wait();
    rready = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    rready = 1'b0;
    @(negedge aclk);
    #1 check("t6_rst_rvalid", rvalid, 0);
    check("t6_rst_rlast", rlast, 0);
    areset = 1'b0;
    model_prio = 0;
    do_read(4'hB, 32'h100, 4'd7, 3'd2, 2'd1);

    // Random traffic, including narrow, aliased and erroneous bursts
    for (int t = 0; t < 60; t++) begin
      tid    = 4'($urandom);
      taddr  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095));
      tlen   = 4'($urandom);
      tsize  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      tburst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        fill_wbuf(1'b1);
        wb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32'(tlen))) : -1;
        lb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32'(tlen))) : -1;
        do_write(tid, taddr, tlen, tsize, tburst, wb, lb);
      end else begin
        do_read(tid, taddr, tlen, tsize, tburst);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
